demux16_deser: RTL and testbench

- Receiving end of the 16:1 bit-select path: it accepts one bit per beat, tagged with a 4-bit select index.
- Each bit is written into the addressed position of a 16-bit assembly register.
- When every position is filled, or on an explicit flush, it presents the assembled word on a valid/ready output port.
- Sits downstream of the bit-select mux and rebuilds the parallel word that the mux serialised.

---
 rtl/demux16_deser.sv | 96 +++++++++
 tb/tb_demux16_deser.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/demux16_deser.sv
// Deserialiser at the receiving end of the bit-select path: rebuilds a parallel word from
// select-tagged single-bit beats and hands it off on a valid/ready port.
module demux16_deser #(
  parameter int   WIDTH      = 16,
  parameter int   SEL_W      = 4,
  parameter logic FILL_VALUE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_bit,
  input  logic [SEL_W-1:0] sel,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_word,
  output logic [WIDTH-1:0] out_mask,
  output logic             err
);

  typedef enum logic {COLLECT, HOLD} state_e;

  localparam logic [WIDTH-1:0] FILL_WORD = {WIDTH{FILL_VALUE}};
  localparam logic [SEL_W:0]   SEL_LIM   = (SEL_W + 1)'(WIDTH);

  state_e           state_q;
  logic [WIDTH-1:0] word_q, mask_q;
  logic [WIDTH-1:0] out_word_q, out_mask_q;
  logic             err_q;

  logic [WIDTH-1:0] word_d, mask_d;
  logic             err_d, beat, in_range, emit;

  assign in_ready  = (state_q == COLLECT) && !rst;
  assign out_valid = (state_q == HOLD);
  assign out_word  = out_word_q;
  assign out_mask  = out_mask_q;
  assign err       = err_q;

  assign beat     = in_valid && in_ready;
  assign in_range = ({1'b0, sel} < SEL_LIM);

  // Same-cycle beat merged into the assembly register; this is what gets emitted
  // when the beat completes the word or coincides with a flush.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    word_d = word_q;
    mask_d = mask_q;
    err_d  = 1'b0;
    if (beat) begin
      if (in_range) begin
        err_d        = mask_q[sel];
        word_d[sel]  = in_bit;
        mask_d[sel]  = 1'b1;
      end else begin
        err_d = 1'b1;
      end
    end
    emit = (&mask_d) || (flush && ((mask_q != '0) || beat));
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (rst) begin
      state_q    <= COLLECT;
      word_q     <= FILL_WORD;
      mask_q     <= '0;
      out_word_q <= FILL_WORD;
      out_mask_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_d;
      unique case (state_q)
        COLLECT: begin
          word_q <= word_d;
          mask_q <= mask_d;
          if (emit) begin
            state_q    <= HOLD;
            out_word_q <= word_d;
            out_mask_q <= mask_d;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q <= COLLECT;
            word_q  <= FILL_WORD;
            mask_q  <= '0;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

endmodule

// File: tb/tb_demux16_deser.sv
// Self-checking bench for demux16_deser: directed scenarios plus random traffic, all
// compared each cycle against a word/flag-array reference model.
module tb_demux16_deser;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_bit, flush, out_ready;
  logic [3:0]  sel;
  logic        in_ready, out_valid, err;
  logic [15:0] out_word, out_mask;

  int n_total = 0;
  int n_bad   = 0;
  int err_seen = 0;

  // Reference model: collected bits, written flags, and the word currently on offer.
  bit          m_hold;
  bit          m_err;
  logic [15:0] m_bits, m_wr, m_word, m_mask;

  always #5 clk = ~clk;

  demux16_deser dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_bit(in_bit),
    .sel(sel), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_mask(out_mask), .err(err)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit had, acc;
    if (rst) begin
      m_hold = 0; m_err = 0;
      m_bits = '0; m_wr = '0; m_word = '0; m_mask = '0;
    end else begin
      m_err = 0;
      if (!m_hold) begin
        had = (m_wr != 0);
        acc = in_valid;
        if (acc) begin
          if (m_wr[sel]) m_err = 1;
          m_bits[sel] = in_bit;
          m_wr[sel]   = 1'b1;
        end
        if ($countones(m_wr) == 16 || (flush && (had || acc))) begin
          m_hold = 1;
          m_word = m_bits;
          m_mask = m_wr;
          m_bits = '0;
          m_wr   = '0;
        end
      end else if (out_ready) begin
        m_hold = 0;
      end
    end
  endtask

  // One clock: drive at the falling edge, compare mid-cycle, advance the model at the rising edge.
  task automatic tick(input logic v, input logic b, input logic [3:0] s,
                      input logic f, input logic r, input logic rs);
    rst = rs; in_valid = v; in_bit = b; sel = s; flush = f; out_ready = r;
    #1;
    if (err) err_seen++;
    check("in_ready", 16'(in_ready), 16'(!m_hold && !rs));
    check("out_valid", 16'(out_valid), 16'(m_hold));
    check("err", 16'(err), 16'(m_err));
    if (m_hold) begin
      check("out_word", out_word, m_word);
      check("out_mask", out_mask, m_mask);
    end
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic send_word(input logic [15:0] d, input logic r);
    for (int i = 0; i < 16; i++) tick(1'b1, d[i], 4'(i), 1'b0, r, 1'b0);
  endtask

  task automatic idle(input logic r);
    tick(1'b0, 1'b0, 4'd0, 1'b0, r, 1'b0);
  endtask

  initial begin
    logic [15:0] d;
    rst = 1'b1; in_valid = 0; in_bit = 0; sel = 0; flush = 0; out_ready = 0;
    m_hold = 0; m_err = 0; m_bits = '0; m_wr = '0; m_word = '0; m_mask = '0;
    @(negedge clk);

    // 1: in-order word
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_word", out_word, 16'h0000);
    check("rst_out_mask", out_mask, 16'h0000);
    check("rst_err", 16'(err), 16'd0);
    send_word(16'hA5C3, 1'b1);
    check("t1_valid", 16'(out_valid), 16'd1);
    check("t1_word", out_word, 16'hA5C3);
    check("t1_mask", out_mask, 16'hFFFF);
    idle(1);
    check("t1_bubble_ready", 16'(in_ready), 16'd1);
    idle(1);

    // 2: reverse order, in_valid every other cycle
    err_seen = 0;
    d = 16'h1234;
    for (int i = 15; i >= 0; i--) begin
      tick(1, d[i], 4'(i), 0, 0, 0);
      if (i != 0) idle(0);
    end
    check("t2_word", out_word, 16'h1234);
    check("t2_mask", out_mask, 16'hFFFF);
    idle(1);
    check("t2_err_count", 16'(err_seen), 16'd0);

    // 3: partial word flushed, then an empty flush
    tick(1, 1, 0, 0, 0, 0);
    tick(1, 0, 1, 0, 0, 0);
    tick(1, 1, 2, 0, 0, 0);
    tick(1, 1, 3, 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    check("t3_word", out_word, 16'h000D);
    check("t3_mask", out_mask, 16'h000F);
    idle(1);
    tick(0, 0, 0, 1, 1, 0);
    check("t3_empty_flush", 16'(out_valid), 16'd0);
    idle(1);

    // 4: duplicate select
    err_seen = 0;
    tick(1, 1, 5, 0, 0, 0);
    tick(1, 0, 5, 0, 0, 0);
    check("t4_err_pulse", 16'(err), 16'd1);
    for (int i = 0; i < 16; i++) if (i != 5) tick(1, 1, 4'(i), 0, 0, 0);
    check("t4_word", out_word, 16'hFFDF);
    idle(1);
    check("t4_err_count", 16'(err_seen), 16'd1);

    // 5: back-pressure with a stalled beat
    send_word(16'h5A5A, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick(1, 1, 0, 0, 0, 0);
      check("t5_hold_word", out_word, 16'h5A5A);
    end
    tick(1, 1, 0, 0, 1, 0);
    send_word(16'h0F0F, 1'b0);
    check("t5_next_word", out_word, 16'h0F0F);
    idle(1);

    // 6: reset mid-word and in HOLD
    for (int i = 0; i < 7; i++) tick(1, 1, 4'(i), 0, 0, 0);
    tick(0, 0, 0, 0, 0, 1);
    rst = 0; in_valid = 0; flush = 0; #1;
    check("t6a_valid", 16'(out_valid), 16'd0);
    check("t6a_mask", out_mask, 16'h0000);
    check("t6a_ready", 16'(in_ready), 16'd1);
    for (int i = 8; i < 12; i++) tick(1, 1, 4'(i), 0, 0, 0);
    tick(0, 0, 0, 1, 0, 0);
    check("t6_flush_mask", out_mask, 16'h0F00);
    check("t6_flush_word", out_word, 16'h0F00);
    tick(0, 0, 0, 0, 0, 1);
    rst = 0; #1;
    check("t6b_valid", 16'(out_valid), 16'd0);
    check("t6b_mask", out_mask, 16'h0000);
    check("t6b_ready", 16'(in_ready), 16'd1);
    send_word(16'hC3A5, 1'b0);
    check("t6_fresh_word", out_word, 16'hC3A5);
    idle(1);

    // Random traffic against the model
    for (int k = 0; k < 600; k++) begin
      tick(1'($urandom_range(0, 9) < 7), 1'($urandom), 4'($urandom),
           1'($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom_range(0, 99) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
